// File: rtl/iir_coef_ctrl.sv
// rtl/iir_coef_ctrl.sv - double-buffered IIR coefficient bank with a swap aligned to sample_en
// Define IIR_COEF_CLR_EN to add a CLEAR state that holds filt_clr for CLR_CYCLES after each swap.
module iir_coef_ctrl #(
    parameter int COEF_W     = 18,
    parameter int FRAC       = 16,
    parameter int CLR_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [2:0]            cfg_addr,
    input  logic [COEF_W-1:0]     cfg_data,
    input  logic                  commit,
    input  logic                  sample_en,
    output logic [5*COEF_W-1:0]   coef_bus,
    output logic                  filt_clr,
    output logic                  busy,
    output logic                  swap_done,
    output logic                  cfg_err
);

    typedef enum logic [1:0] {IDLE, PEND, SWAP, CLEAR} state_t;

    localparam logic [COEF_W-1:0] UNITY = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC;

    state_t            state;
    logic [COEF_W-1:0] shadow [5];
    logic [COEF_W-1:0] active [5];
    logic              wr_acc;

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign wr_acc    = cfg_valid && cfg_ready;

    for (genvar g = 0; g < 5; g++) begin : g_bus
        assign coef_bus[g*COEF_W +: COEF_W] = active[g];
    end

`ifdef IIR_COEF_CLR_EN
    localparam int CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    logic [CW-1:0] clr_cnt;
    assign filt_clr = (state == CLEAR);
`else
    assign filt_clr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            swap_done <= 1'b0;
            cfg_err   <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                shadow[i] <= (i == 0) ? UNITY : '0;
                active[i] <= (i == 0) ? UNITY : '0;
            end
`ifdef IIR_COEF_CLR_EN
            clr_cnt   <= '0;
`endif
        end else begin
            swap_done <= 1'b0;
            cfg_err   <= 1'b0;

            if (wr_acc) begin
                if (cfg_addr <= 3'd4)
                    shadow[cfg_addr] <= cfg_data;
                else
                    cfg_err <= 1'b1;
            end
            if (commit && state != IDLE)
                cfg_err <= 1'b1;

            case (state)
                IDLE: if (commit) state <= PEND;
                // A sample_en in the commit cycle is seen while still in IDLE, so it never counts.
                PEND: if (sample_en) state <= SWAP;
                SWAP: begin
                    for (int i = 0; i < 5; i++)
                        active[i] <= shadow[i];
                    swap_done <= 1'b1;
`ifdef IIR_COEF_CLR_EN
                    clr_cnt   <= '0;
                    state     <= CLEAR;
`else
                    state     <= IDLE;
`endif
                end
`ifdef IIR_COEF_CLR_EN
                CLEAR: begin
                    if (clr_cnt == CW'(CLR_CYCLES - 1))
                        state <= IDLE;
                    else
                        clr_cnt <= clr_cnt + CW'(1);
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iir_coef_ctrl.sv
// tb/tb_iir_coef_ctrl.sv - directed self-checking bench for iir_coef_ctrl
module tb_iir_coef_ctrl;

    localparam int W = 18;
`ifdef IIR_COEF_CLR_EN
    localparam int CLR_N = 4;
`else
    localparam int CLR_N = 0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [2:0]      cfg_addr = '0;
    logic [W-1:0]    cfg_data = '0;
    logic            commit = 1'b0;
    logic            sample_en = 1'b0;
    logic [5*W-1:0]  coef_bus;
    logic            filt_clr, busy, swap_done, cfg_err;

    iir_coef_ctrl dut (
        .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .commit(commit), .sample_en(sample_en),
        .coef_bus(coef_bus), .filt_clr(filt_clr), .busy(busy),
        .swap_done(swap_done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    // Reference model: the two banks as plain arrays plus the expected handshake/status levels.
    logic signed [W-1:0] e_shadow [5];
    logic signed [W-1:0] e_active [5];
    logic e_ready, e_busy, e_clr, e_done, e_err;
    bit   chk_en = 1'b0;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [5*W-1:0] pack_active();
        logic [5*W-1:0] p;
        for (int i = 0; i < 5; i++) p[i*W +: W] = e_active[i];
        return p;
    endfunction

    task automatic chk_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic compare();
        logic [5*W-1:0] eb;
        if (!chk_en) return;
        eb = pack_active();
        checks++;
        if (coef_bus !== eb) begin
            errors++;
            $display("FAIL coef_bus t=%0t got %h expected %h", $time, coef_bus, eb);
        end
        chk_bit("cfg_ready", cfg_ready, e_ready);
        chk_bit("busy", busy, e_busy);
        chk_bit("filt_clr", filt_clr, e_clr);
        chk_bit("swap_done", swap_done, e_done);
        chk_bit("cfg_err", cfg_err, e_err);
    endtask

    // Check the current cycle at the falling edge, then advance one clock; pulse inputs drop afterwards.
    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        commit    = 1'b0;
        sample_en = 1'b0;
        e_done    = 1'b0;
        e_err     = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            e_shadow[i] = (i == 0) ? 18'sd65536 : 18'sd0;
            e_active[i] = e_shadow[i];
        end
        e_ready = 1'b1; e_busy = 1'b0; e_clr = 1'b0; e_done = 1'b0; e_err = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
    endtask

    task automatic wr(input logic [2:0] a, input logic signed [W-1:0] d);
        cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
        tick();
        if (a <= 3'd4) e_shadow[a] = d;
        else           e_err = 1'b1;
    endtask

    // Commit (optionally with a same-cycle write), sample_en `gap` cycles later, optional
    // extra commit while pending, optional reset `abort_at` cycles into the post-swap phase.
    task automatic run_swap(input bit do_wr, input logic [2:0] wa, input logic signed [W-1:0] wd,
                            input int gap, input int extra_commit, input int abort_at);
        cfg_valid = do_wr; cfg_addr = wa; cfg_data = wd;
        commit = 1'b1; sample_en = 1'b1;
        tick();
        if (do_wr && wa <= 3'd4) e_shadow[wa] = wd;
        e_ready = 1'b0; e_busy = 1'b1;
        for (int k = 1; k < gap; k++) begin
            if (k == extra_commit) commit = 1'b1;
            tick();
            if (k == extra_commit) e_err = 1'b1;
        end
        sample_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) e_active[i] = e_shadow[i];
        e_done = 1'b1;
        if (CLR_N > 0) e_clr = 1'b1;
        else begin e_busy = 1'b0; e_ready = 1'b1; end
        for (int c = 1; c < CLR_N; c++) begin
            if (c == abort_at) begin
                do_reset();
                return;
            end
            tick();
        end
        if (CLR_N > 0) begin
            tick();
            e_clr = 1'b0; e_busy = 1'b0; e_ready = 1'b1;
        end
        if (abort_at > 0) begin
            tick();
            do_reset();
        end
    endtask

    initial begin
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;

        chk_int("reset_b0", int'(coef_bus[17:0]), 65536);
        chk_int("reset_upper", int'(coef_bus[89:18] != 0), 0);
        chk_bit("reset_ready", cfg_ready, 1'b1);
        chk_bit("reset_busy", busy, 1'b0);
        tick();

        // Basic swap; sample_en in the commit cycle must be ignored.
        wr(3'd0, 18'sd30000);
        wr(3'd3, -18'sd20000);
        tick();
        run_swap(1'b0, 3'd0, 18'sd0, 5, 0, 0);
        chk_int("swap_b0", int'($signed(coef_bus[17:0])), 30000);
        chk_int("swap_a1", int'($signed(coef_bus[71:54])), -20000);
        tick();

        // Illegal address, then re-commit reloads the unchanged shadow.
        wr(3'd6, 18'sd999);
        tick();
        run_swap(1'b0, 3'd0, 18'sd0, 2, 0, 0);
        chk_int("recommit_b0", int'($signed(coef_bus[17:0])), 30000);
        tick();

        // Commit while pending is rejected and only one swap happens.
        wr(3'd1, -18'sd5);
        run_swap(1'b0, 3'd0, 18'sd0, 4, 2, 0);
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1;
            tick();
        end
        chk_int("pend_b1", int'($signed(coef_bus[35:18])), -5);

        // Write and commit in the same cycle.
        run_swap(1'b1, 3'd2, 18'sd123, 2, 0, 0);
        chk_int("same_cycle_b2", int'($signed(coef_bus[53:36])), 123);
        tick();

        // Reset two cycles into the post-swap clear window.
        run_swap(1'b1, 3'd1, 18'sd777, 3, 0, 2);
        chk_bit("abort_clr", filt_clr, 1'b0);
        chk_int("abort_b0", int'(coef_bus[17:0]), 65536);
        chk_int("abort_b1", int'(coef_bus[35:18]), 0);
        for (int i = 0; i < 3; i++) begin
            sample_en = 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/iir_coef_ctrl.md
IIR_COEF_CTRL -- requirements
Module: iir_coef_ctrl

Interface
REQ-001 SHALL have parameter COEF_W, default 18: width of each signed coefficient.
REQ-002 SHALL have parameter FRAC, default 16: number of fractional bits in each coefficient (Q format).
REQ-003 SHALL have parameter CLR_CYCLES, default 4: number of cycles filt_clr is held after a swap.
REQ-004 SHALL have port clk, input, 1 bit: clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port cfg_valid, input, 1 bit: coefficient write request.
REQ-007 SHALL have port cfg_ready, output, 1 bit: a write is accepted when cfg_valid and cfg_ready are both high.
REQ-008 SHALL have port cfg_addr, input, 3 bits: coefficient select; 0=b0, 1=b1, 2=b2, 3=a1, 4=a2.
REQ-009 SHALL have port cfg_data, input, COEF_W bits: signed coefficient value.
REQ-010 SHALL have port commit, input, 1 bit: single-cycle pulse requesting a bank swap.
REQ-011 SHALL have port sample_en, input, 1 bit: the filter datapath's sample boundary strobe.
REQ-012 SHALL have port coef_bus, output, 5*COEF_W bits: the active coefficients, b0 in the LSBs through a2 in the MSBs.
REQ-013 SHALL have port filt_clr, output, 1 bit: clear request for the filter state registers.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-015 SHALL have port swap_done, output, 1 bit: one-cycle pulse marking the swap.
REQ-016 SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging an illegal address or a rejected commit.

Function
REQ-017 SHALL hold two banks: a shadow bank written through the cfg port, and an active bank driven onto coef_bus.
REQ-018 SHALL implement FSM states IDLE, PEND, SWAP and CLEAR.
REQ-019 SHALL drive cfg_ready high only in IDLE.
REQ-020 SHALL write cfg_data into the shadow entry selected by cfg_addr on an accepted write; the register updates on the next edge.
REQ-021 SHALL, for an accepted write with cfg_addr > 4, leave both banks unchanged and pulse cfg_err for one cycle on the next cycle.
REQ-022 SHALL move IDLE -> PEND on commit.
REQ-023 SHALL, when an accepted write and commit occur in the same cycle, store the write and include it in the committed bank.
REQ-024 SHALL move PEND -> SWAP on the first sample_en seen while in PEND; a sample_en in the commit cycle itself does not count.
REQ-025 SHALL, in SWAP, copy all five shadow entries into the active bank in a single edge, so coef_bus never shows a mixed bank.
REQ-026 SHALL pulse swap_done in the cycle after SWAP, i.e. the first cycle coef_bus carries the new values.
REQ-027 SHALL, in SWAP with IIR_COEF_CLR_EN defined, move to CLEAR.
REQ-028 SHALL, in CLEAR, hold filt_clr high for exactly CLR_CYCLES cycles, then return to IDLE.
REQ-029 SHALL ignore sample_en in IDLE, SWAP and CLEAR.
REQ-030 SHALL ignore commit while not in IDLE and pulse cfg_err for one cycle on the next cycle.
REQ-031 SHALL keep shadow contents after a swap, so a repeated commit reloads the same values.

Reset
REQ-032 SHALL, on reset, return the FSM to IDLE and clear the CLEAR counter.
REQ-033 SHALL, on reset, load both banks with passthrough values: b0 = 2^FRAC (65536 by default); b1, b2, a1, a2 = 0.
REQ-034 SHALL, on reset, drive filt_clr, busy, swap_done and cfg_err low and cfg_ready high from the first cycle after reset.
REQ-035 SHALL, on reset during PEND, SWAP or CLEAR, abort the operation immediately, with no further swap or filt_clr.

Configuration
REQ-036 SHALL, with macro IIR_COEF_CLR_EN defined, implement the CLEAR state and drive filt_clr as specified above.
REQ-037 SHALL, without IIR_COEF_CLR_EN, omit the CLEAR state and counter, tie filt_clr to 0 and move SWAP -> IDLE directly.

Verification
REQ-038 SHALL cover: after reset -> coef_bus b0 field = 65536, other fields = 0, cfg_ready = 1, busy = 0.
REQ-039 SHALL cover: write b0=30000, a1=-20000, commit, sample_en 5 cycles later -> coef_bus unchanged until SWAP, swap_done one cycle after SWAP, filt_clr high 4 cycles (macro on), then IDLE.
REQ-040 SHALL cover: write with cfg_addr=6 -> cfg_err pulses once and both banks are unchanged.
REQ-041 SHALL cover: commit pulsed in PEND -> cfg_err pulses and exactly one swap occurs.
REQ-042 SHALL cover: write and commit in the same cycle (b2=123) -> the b2 field becomes 123 after the swap.
REQ-043 SHALL cover: reset asserted in CLEAR after 2 cycles -> filt_clr low next cycle and coef_bus returns to passthrough.
